if_fetch_unit: RTL and testbench

//  Instruction-fetch producer that drives the IF side of the IF/ID pipeline register.
//  - Generates the fetch PC and issues in-order requests to instruction memory.
//  - Buffers returned words with their PC in a small FIFO.
//  - Presents {pc, instr_IF} and holds them while ID stalls (keep_instr).
//  - On branch/jalr redirect: flushes the FIFO and discards in-flight responses.

---
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave): in-order req/gnt issue, rvalid/rdata return.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage producer: issues in-order fetches, buffers {pc, instr} words and feeds ID.
// Optional macro IF_BYPASS_EN forwards a response straight to ID when the buffer is empty.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  if_fetch_unit_if.master        imem,
  input  logic                   keep_instr,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            pc,
  output logic [31:0]            instr_IF,
  output logic                   instr_valid_IF,
  output logic                   pc_running
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_W = FIFO_DEPTH[CNT_W:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOOT,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       resp_pc_q;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;

  logic [31:0]       pc_mem    [FIFO_DEPTH];
  logic [31:0]       instr_mem [FIFO_DEPTH];

  logic [CNT_W:0]    inflight;
  logic              grant;
  logic              rsp_ok;
  logic              rsp_drop;
  logic              rsp_take;
  logic              push;
  logic              pop;
  logic              pop_fifo;
  logic              fifo_empty;
  logic [31:0]       redirect_target;

  // ---------------------------------------------------------------------------
  // Start-up sequencer
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case/if leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_BOOT;
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  assign pc_running = (state_q == S_RUN);

  // ---------------------------------------------------------------------------
  // Request issue: buffered words plus in-flight requests never exceed the
  // buffer, so every response that is kept always has a free slot.
  // ---------------------------------------------------------------------------
  assign inflight  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem.req  = pc_running && (inflight < DEPTH_W) && !redirect_valid;
  assign imem.addr = fetch_pc_q;
  assign grant     = imem.req && imem.gnt;

  assign redirect_target = redirect_pc & ~32'h3;

  // Responses with nothing outstanding (e.g. after a mid-flight reset) are stale.
  assign rsp_ok   = imem.rvalid && (outstanding_q != '0);
  assign rsp_drop = rsp_ok && (drop_q != '0);
  assign rsp_take = rsp_ok && (drop_q == '0);

  assign outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp_ok);

  // ---------------------------------------------------------------------------
  // Presentation to ID
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);

`ifdef IF_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass         = 1'b0;
    pc             = resp_pc_q;
    instr_IF       = '0;
    instr_valid_IF = 1'b0;
    if (!fifo_empty) begin
      pc             = pc_mem[rd_ptr_q];
      instr_IF       = instr_mem[rd_ptr_q];
      instr_valid_IF = 1'b1;
    end else if (rsp_take && !redirect_valid) begin
      bypass         = 1'b1;
      instr_IF       = imem.rdata;
      instr_valid_IF = 1'b1;
    end
  end

  // A forwarded word that ID consumes right away never needs a buffer slot.
  assign push = rsp_take && !redirect_valid && !(bypass && pop);
`else
  always_comb begin
    pc             = resp_pc_q;
    instr_IF       = '0;
    instr_valid_IF = 1'b0;
    if (!fifo_empty) begin
      pc             = pc_mem[rd_ptr_q];
      instr_IF       = instr_mem[rd_ptr_q];
      instr_valid_IF = 1'b1;
    end
  end

  assign push = rsp_take && !redirect_valid;
`endif

  assign pop      = instr_valid_IF && !keep_instr && !redirect_valid;
  assign pop_fifo = pop && !fifo_empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop_fifo})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        // Everything still in flight belongs to the abandoned stream.
        fetch_pc_q <= redirect_target;
        resp_pc_q  <= redirect_target;
        drop_q     <= outstanding_d;
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
      end else begin
        if (grant) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (rsp_drop) begin
          drop_q <= drop_q - CNT_W'(1);
        end
        if (rsp_take) begin
          resp_pc_q <= resp_pc_q + 32'd4;
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop_fifo) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        count_q <= count_d;
      end
    end
  end

  // NOTE: the buffer storage has no reset; the count and pointers guarantee an
  // entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= imem.rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model with tagged responses and
// an expected-instruction queue filled as responses are driven.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef IF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        keep_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] instr_IF;
  logic        instr_valid_IF;
  logic        pc_running;

  if_fetch_unit_if imem_bus();

  if_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus),
    .keep_instr     (keep_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .instr_IF       (instr_IF),
    .instr_valid_IF (instr_valid_IF),
    .pc_running     (pc_running)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          mem_lat  = 1;
  int          force_rv = 0;
  logic        gnt_en   = 1'b1;
  logic        keep     = 1'b0;
  logic        redir    = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        rst_drv  = 1'b1;
  logic [31:0] exp_addr = RESET_PC;

  pend_t       pend_q[$];
  logic [63:0] sb_q[$];
  logic [31:0] grant_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, well before the rising edge.
  task automatic tick();
    pend_t p;
    @(negedge clk);
    cyc++;
    rst            = rst_drv;
    keep_instr     = keep;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    if (rst_drv) begin
      pend_q.delete();
      sb_q.delete();
      epoch++;
      exp_addr = RESET_PC;
    end
    if (redir) begin
      epoch++;
      sb_q.delete();
      exp_addr = redir_pc & ~32'h3;
    end
    imem_bus.gnt    = gnt_en;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    if (force_rv > 0) begin
      force_rv--;
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'hDEAD_BEEF;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = p.addr ^ KEY;
      if (p.epoch == epoch) sb_q.push_back({p.addr, p.addr ^ KEY});
    end
    #1;
    if (imem_bus.req) begin
      check("imem_addr", imem_bus.addr, exp_addr);
      if (imem_bus.gnt) begin
        pend_q.push_back('{addr: exp_addr, due: cyc + mem_lat, epoch: epoch});
        grant_log.push_back(imem_bus.addr);
        exp_addr += 32'd4;
      end
    end
    if (!redir && !rst_drv && instr_valid_IF) begin
      if (sb_q.size() == 0) begin
        check("stale_instr_valid", {31'b0, instr_valid_IF}, 32'h0);
      end else begin
        check("pc", pc, sb_q[0][63:32]);
        check("instr_IF", instr_IF, sb_q[0][31:0]);
        if (!keep) begin
          void'(sb_q.pop_front());
          n_pop++;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req"},     {31'b0, imem_bus.req},   32'h0);
    check({pfx, "_addr"},    imem_bus.addr,           RESET_PC);
    check({pfx, "_pc"},      pc,                      RESET_PC);
    check({pfx, "_instr"},   instr_IF,                32'h0);
    check({pfx, "_valid"},   {31'b0, instr_valid_IF}, 32'h0);
    check({pfx, "_running"}, {31'b0, pc_running},     32'h0);
  endtask

  initial begin
    int  pops_before;
    logic found;

    keep_instr      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");

    // Test 1: start-up sequence and in-order streaming
    rst_drv = 1'b0;
    tick();
    check("idle_running", {31'b0, pc_running},   32'h0);
    check("idle_req",     {31'b0, imem_bus.req}, 32'h0);
    tick();
    check("boot_running", {31'b0, pc_running},   32'h0);
    check("boot_req",     {31'b0, imem_bus.req}, 32'h0);
    tick();
    check("run_running",  {31'b0, pc_running},   32'h1);
    check("run_req",      {31'b0, imem_bus.req}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (imem_bus.rvalid) found = 1'b1;
    end
    check("first_rvalid_seen", {31'b0, found}, 32'h1);
    check("latency_same_cycle", {31'b0, instr_valid_IF}, {31'b0, BYP});
    tick();
    check("latency_next_cycle", {31'b0, instr_valid_IF}, 32'h1);
    repeat (12) tick();
    check("t1_progress", {31'b0, n_pop >= 5}, 32'h1);

    // Test 2: ID stall holds the output and throttles requests
    keep = 1'b1;
    repeat (5) tick();
    check("keep_req_off", {31'b0, imem_bus.req},   32'h0);
    check("keep_valid",   {31'b0, instr_valid_IF}, 32'h1);
    keep = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (imem_bus.req) found = 1'b1;
    end
    check("keep_resume_req", {31'b0, found}, 32'h1);
    repeat (4) tick();

    // Test 3: redirect with two requests outstanding
    mem_lat = 3;
    for (int i = 0; i < 30 && pend_q.size() != 2; i++) tick();
    check("t3_two_outstanding", pend_q.size(), 32'd2);
    redir    = 1'b1;
    redir_pc = 32'h0000_0103;
    tick();
    check("t3_req_withdrawn", {31'b0, imem_bus.req}, 32'h0);
    redir = 1'b0;
    tick();
    check("t3_empty_pc",    pc,                      32'h0000_0100);
    check("t3_empty_valid", {31'b0, instr_valid_IF}, 32'h0);
    pops_before = n_pop;
    repeat (20) tick();
    check("t3_progress", {31'b0, n_pop > pops_before}, 32'h1);

    // Test 4: redirect in the same cycle as a response and an offered grant
    mem_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pend_q.size() > 0 && pend_q[0].due == cyc + 1) found = 1'b1;
    end
    check("t4_setup", {31'b0, found}, 32'h1);
    redir    = 1'b1;
    redir_pc = 32'h0000_0200;
    tick();
    check("t4_rvalid_at_redirect", {31'b0, imem_bus.rvalid}, 32'h1);
    check("t4_req_withdrawn",      {31'b0, imem_bus.req},    32'h0);
    redir = 1'b0;
    tick();
    check("t4_no_stale_valid", {31'b0, instr_valid_IF}, 32'h0);
    check("t4_empty_pc",       pc,                      32'h0000_0200);
    pops_before = n_pop;
    repeat (15) tick();
    check("t4_progress", {31'b0, n_pop > pops_before}, 32'h1);

    // Test 5: fetch address wraps past the top of memory
    mem_lat = 1;
    grant_log.delete();
    redir    = 1'b1;
    redir_pc = 32'hFFFF_FFF8;
    tick();
    redir = 1'b0;
    repeat (15) tick();
    check("wrap_grant_cnt", {31'b0, grant_log.size() >= 3}, 32'h1);
    if (grant_log.size() >= 3) begin
      check("wrap_addr0", grant_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", grant_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", grant_log[2], 32'h0000_0000);
    end

    // Test 6: reset with two requests in flight, then late responses
    mem_lat = 3;
    for (int i = 0; i < 30 && pend_q.size() != 2; i++) tick();
    check("t6_two_outstanding", pend_q.size(), 32'd2);
    rst_drv = 1'b1;
    tick();
    check_reset_outputs("t6_reset");
    tick();
    rst_drv  = 1'b0;
    force_rv = 2;
    tick();
    check("t6_idle_running", {31'b0, pc_running},     32'h0);
    check("t6_idle_valid",   {31'b0, instr_valid_IF}, 32'h0);
    tick();
    check("t6_boot_running", {31'b0, pc_running},     32'h0);
    check("t6_boot_valid",   {31'b0, instr_valid_IF}, 32'h0);
    tick();
    check("t6_run_running",  {31'b0, pc_running},     32'h1);
    check("t6_run_valid",    {31'b0, instr_valid_IF}, 32'h0);
    check("t6_restart_req",  {31'b0, imem_bus.req},   32'h1);
    check("t6_restart_addr", imem_bus.addr,           RESET_PC);
    mem_lat = 1;
    repeat (10) tick();

    // Drain: stop granting and let every expected word reach ID
    gnt_en = 1'b0;
    repeat (8) tick();
    check("final_drain", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
